// File: rtl/approx_adder_pkg.sv
// Shared widths and FSM encoding for the approximate-adder arbiter slice.
package approx_adder_pkg;

    localparam int unsigned ADD_W = 16;
    localparam int unsigned SUM_W = 17;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_e;

endpackage

// File: rtl/xnor_based_ripple_carry_adder16.sv
// 16-bit approximate ripple adder: each cell's sum is XNOR of its operand bits,
// while the carry chain is exact, so result_o[16] is the true carry-out.
module xnor_based_ripple_carry_adder16
    import approx_adder_pkg::*;
(
    input  logic [ADD_W-1:0] add1_i,
    input  logic [ADD_W-1:0] add2_i,
    output logic [SUM_W-1:0] result_o
);

    logic [ADD_W:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < ADD_W; i++) begin : g_cell
        assign result_o[i]  = ~(add1_i[i] ^ add2_i[i]);
        assign carry[i+1]   = (add1_i[i] & add2_i[i]) | (carry[i] & (add1_i[i] ^ add2_i[i]));
    end

    assign result_o[ADD_W] = carry[ADD_W];

endmodule

// File: rtl/approx_adder16_arbiter.sv
// Round-robin scheduler sharing one approximate 16-bit adder among NUM_REQ
// requesters; one operation in flight at a time (IDLE -> EXEC -> RESP).
module approx_adder16_arbiter
    import approx_adder_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*ADD_W-1:0] req_a_i,
    input  logic [NUM_REQ*ADD_W-1:0] req_b_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic [SUM_W-1:0]         rsp_sum_o,
    output logic                     busy_o,
    output logic [15:0]              op_count_o
);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  last_ptr_q, last_ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ADD_W-1:0] op_a_q, op_a_d;
    logic [ADD_W-1:0] op_b_q, op_b_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [15:0]      op_count_q, op_count_d;

    logic [SUM_W-1:0] add_sum;
    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand_idx;

    xnor_based_ripple_carry_adder16 u_adder (
        .add1_i   (op_a_q),
        .add2_i   (op_b_q),
        .result_o (add_sum)
    );

    // Scan starts one past the last winner, so the previous grantee has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand_idx = ID_W'((32'(last_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_ptr_d  = last_ptr_q;
        id_d        = id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sum_d       = sum_q;
        op_count_d  = op_count_q;
        req_ready_o = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready_o[grant_idx] = 1'b1;
                    op_a_d     = req_a_i[grant_idx*ADD_W +: ADD_W];
                    op_b_d     = req_b_i[grant_idx*ADD_W +: ADD_W];
                    id_d       = grant_idx;
                    last_ptr_d = grant_idx;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                sum_d   = add_sum;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            last_ptr_q <= ID_W'(NUM_REQ - 1);
            id_q       <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            sum_q      <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            last_ptr_q <= last_ptr_d;
            id_q       <= id_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            sum_q      <= sum_d;
            op_count_q <= op_count_d;
        end
    end

    assign rsp_valid_o = (state_q == RESP);
    assign busy_o      = (state_q != IDLE);
    assign rsp_id_o    = id_q;
    assign rsp_sum_o   = sum_q;
    assign op_count_o  = op_count_q;

endmodule

// File: tb/tb_approx_adder16_arbiter.sv
// Directed bench for approx_adder16_arbiter: grant order, latency, back-pressure,
// reset abort, counter wrap and withdrawn requests.
module tb_approx_adder16_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [16:0] rsp_sum;
    logic        busy;
    logic [15:0] op_count;

    int n_cmp = 0;
    int n_err = 0;

    approx_adder16_arbiter #(.NUM_REQ(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_sum_o   (rsp_sum),
        .busy_o      (busy),
        .op_count_o  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Low half: bitwise XNOR of operands; bit 16: carry-out of the true sum.
    function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {s[16], ~(a ^ b)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    logic [15:0] opa [4];
    logic [15:0] opb [4];
    logic [1:0]  exp_ids [5];
    int          got;

    initial begin
        opa[0] = 16'h1100; opb[0] = 16'h1111;
        opa[1] = 16'h8116; opb[1] = 16'h1CCE;
        opa[2] = 16'h4482; opb[2] = 16'h3BCD;
        opa[3] = 16'h5555; opb[3] = 16'hAAAA;
        exp_ids[0] = 2'd0; exp_ids[1] = 2'd1; exp_ids[2] = 2'd2;
        exp_ids[3] = 2'd3; exp_ids[4] = 2'd0;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_id",    32'(rsp_id),    32'h0);
        chk("rst_sum",   32'(rsp_sum),   32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_count", 32'(op_count),  32'h0);
        rst_n = 1'b1;

        // Single request from requester 2
        @(negedge clk);
        req_a[32 +: 16] = 16'h29AF;
        req_b[32 +: 16] = 16'h7A1B;
        req_valid = 4'b0100;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = '0;
        chk("t1_exec_busy",  32'(busy),      32'h1);
        chk("t1_exec_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_id",    32'(rsp_id),    32'h2);
        chk("t1_rsp_sum",   32'(rsp_sum),   32'(ref_sum(16'h29AF, 16'h7A1B)));
        chk("t1_rsp_sum_k", 32'(rsp_sum),   32'h0AC4B);
        @(negedge clk);
        chk("t1_count", 32'(op_count),  32'h1);
        chk("t1_done",  32'(rsp_valid), 32'h0);

        // Reset restores requester 0 as first priority for the rotation test
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a[16*i +: 16] = opa[i];
            req_b[16*i +: 16] = opb[i];
        end
        req_valid = 4'b1111;
        got = 0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                chk("rr_id",  32'(rsp_id),  32'(exp_ids[got]));
                chk("rr_sum", 32'(rsp_sum), 32'(ref_sum(opa[exp_ids[got]], opb[exp_ids[got]])));
                got++;
                if (got == 5) req_valid = '0;
            end
        end
        chk("rr_count_rsp", 32'(got), 32'd5);
        @(negedge clk);
        chk("rr_op_count", 32'(op_count), 32'd5);

        // Back-pressure: requesters 1 and 3 contend, last winner was 0
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("bp_grant1", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_rsp(5);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_id",    32'(rsp_id),    32'h1);
            chk("bp_sum",   32'(rsp_sum),   32'(ref_sum(opa[1], opb[1])));
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_count", 32'(op_count),  32'd5);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_valid", 32'(rsp_valid), 32'h0);
        chk("bp_rel_count", 32'(op_count),  32'd6);
        chk("bp_next_gnt",  32'(req_ready), 32'h8);
        @(negedge clk);
        req_valid[3] = 1'b0;
        wait_rsp(5);
        chk("bp3_id",  32'(rsp_id),  32'h3);
        chk("bp3_sum", 32'(rsp_sum), 32'(ref_sum(opa[3], opb[3])));

        // Withdrawn request: requester 1 raises and drops valid while in RESP
        rsp_ready = 1'b0;
        req_valid[1] = 1'b1;
        @(negedge clk);
        chk("wd_ready_resp", 32'(req_ready), 32'h0);
        chk("wd_hold",       32'(rsp_valid), 32'h1);
        req_valid[1] = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wd_no_grant", 32'(req_ready), 32'h0);
            chk("wd_no_rsp",   32'(rsp_valid), 32'h0);
        end
        chk("wd_count", 32'(op_count), 32'd7);

        // Reset mid-EXEC with requester 2 in flight
        req_valid = 4'b0100;
        #1;
        chk("rx_grant2", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = '0;
        chk("rx_exec_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rx_ready", 32'(req_ready), 32'h0);
        chk("rx_valid", 32'(rsp_valid), 32'h0);
        chk("rx_id",    32'(rsp_id),    32'h0);
        chk("rx_sum",   32'(rsp_sum),   32'h0);
        chk("rx_busy",  32'(busy),      32'h0);
        chk("rx_count", 32'(op_count),  32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rx_no_rsp", 32'(rsp_valid), 32'h0);
        end
        req_valid = 4'b1001;
        #1;
        chk("rx_contend", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(5);
        chk("rx_rsp_id",  32'(rsp_id),  32'h0);
        chk("rx_rsp_sum", 32'(rsp_sum), 32'(ref_sum(opa[0], opb[0])));
        @(negedge clk);
        chk("rx_count1", 32'(op_count), 32'd1);

        // Counter wrap via preload
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        #1;
        chk("wrap_pre", 32'(op_count), 32'hFFFF);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(5);
        chk("wrap_id", 32'(rsp_id), 32'h1);
        @(negedge clk);
        chk("wrap_post", 32'(op_count), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
